// File: rtl/as_ethernet_pkt_gen.sv
// Builds one 60-byte Ethernet/IPv4 alert packet per accepted request onto the 64-bit user datapath.
// Define AS_PKT_GEN_CKSUM_EN to compute the IPv4 header checksum (adds one CSUM cycle); otherwise it is 0.
module as_ethernet_pkt_gen #(
   parameter int         DATA_WIDTH  = 64,
   parameter int         CTRL_WIDTH  = DATA_WIDTH / 8,
   parameter int         NUM_IQ_BITS = 3,
   parameter logic [7:0] IP_TTL      = 8'd64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [47:0]            req_dst_mac,
   input  logic [47:0]            req_src_mac,
   input  logic [31:0]            req_src_ip,
   input  logic [31:0]            req_dst_ip,
   input  logic [7:0]             req_proto,
   input  logic [NUM_IQ_BITS-1:0] req_dst_port,
   input  logic [NUM_IQ_BITS-1:0] req_src_port,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [CTRL_WIDTH-1:0]  out_ctrl,
   output logic                   out_wr,
   input  logic                   out_rdy,
   output logic [31:0]            tx_pkt_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
`ifdef AS_PKT_GEN_CKSUM_EN
      ST_CSUM,
`endif
      ST_SEND
   } state_t;

   state_t                 state_q;
   logic                   req_ready_q;
   logic [3:0]             cnt_q;
   logic [63:0]            out_data_q;
   logic [7:0]             out_ctrl_q;
   logic [31:0]            tx_pkt_cnt_q;
   logic [15:0]            ip_id_q;
   logic [47:0]            dst_mac_q;
   logic [47:0]            src_mac_q;
   logic [31:0]            src_ip_q;
   logic [31:0]            dst_ip_q;
   logic [7:0]             proto_q;
   logic [NUM_IQ_BITS-1:0] dst_port_q;
   logic [NUM_IQ_BITS-1:0] src_port_q;
   logic [15:0]            cksum_s;

   function automatic logic [63:0] hdr_word(input logic [NUM_IQ_BITS-1:0] dport,
                                            input logic [NUM_IQ_BITS-1:0] sport);
      logic [15:0] onehot;
      onehot   = 16'd1 << dport;
      hdr_word = {onehot, 16'd8, 16'(sport), 16'd60};
   endfunction

   function automatic logic [63:0] body_word(input logic [3:0] idx, input logic [47:0] dmac,
                                             input logic [47:0] smac, input logic [31:0] sip,
                                             input logic [31:0] dip, input logic [15:0] id,
                                             input logic [7:0] proto, input logic [15:0] ck);
      case (idx)
         4'd1:    body_word = {dmac, smac[47:32]};
         4'd2:    body_word = {smac[31:0], 16'h0800, 8'h45, 8'h00};
         4'd3:    body_word = {16'd46, id, 16'h4000, IP_TTL, proto};
         4'd4:    body_word = {ck, sip, dip[31:16]};
         4'd5:    body_word = {dip[15:0], 48'h0};
         default: body_word = 64'h0;
      endcase
   endfunction

`ifdef AS_PKT_GEN_CKSUM_EN
   logic [15:0] cksum_q;

   // Nine header halfwords fit a 20-bit sum; two folds absorb every end-around carry.
   function automatic logic [15:0] ip_cksum(input logic [15:0] id, input logic [7:0] proto,
                                            input logic [31:0] sip, input logic [31:0] dip);
      logic [19:0] acc;
      logic [16:0] f1;
      logic [15:0] f2;
      acc = 20'h04500 + 20'h0002E + {4'h0, id} + 20'h04000 + {4'h0, IP_TTL, proto}
          + {4'h0, sip[31:16]} + {4'h0, sip[15:0]} + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
      f1  = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
      f2  = f1[15:0] + {15'h0, f1[16]};
      ip_cksum = ~f2;
   endfunction

   assign cksum_s = cksum_q;
`else
   assign cksum_s = 16'h0000;
`endif

   // Request capture, packet sequencing and registered datapath outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b0;
         cnt_q        <= 4'd0;
         out_data_q   <= 64'h0;
         out_ctrl_q   <= 8'h00;
         tx_pkt_cnt_q <= 32'd0;
         ip_id_q      <= 16'd0;
         dst_mac_q    <= 48'h0;
         src_mac_q    <= 48'h0;
         src_ip_q     <= 32'h0;
         dst_ip_q     <= 32'h0;
         proto_q      <= 8'h00;
         dst_port_q   <= '0;
         src_port_q   <= '0;
`ifdef AS_PKT_GEN_CKSUM_EN
         cksum_q      <= 16'h0000;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  dst_mac_q   <= req_dst_mac;
                  src_mac_q   <= req_src_mac;
                  src_ip_q    <= req_src_ip;
                  dst_ip_q    <= req_dst_ip;
                  proto_q     <= req_proto;
                  dst_port_q  <= req_dst_port;
                  src_port_q  <= req_src_port;
                  cnt_q       <= 4'd0;
                  req_ready_q <= 1'b0;
`ifdef AS_PKT_GEN_CKSUM_EN
                  state_q     <= ST_CSUM;
`else
                  out_data_q  <= hdr_word(req_dst_port, req_src_port);
                  out_ctrl_q  <= 8'hFF;
                  state_q     <= ST_SEND;
`endif
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
`ifdef AS_PKT_GEN_CKSUM_EN
            ST_CSUM: begin
               cksum_q    <= ip_cksum(ip_id_q, proto_q, src_ip_q, dst_ip_q);
               out_data_q <= hdr_word(dst_port_q, src_port_q);
               out_ctrl_q <= 8'hFF;
               state_q    <= ST_SEND;
            end
`endif
            ST_SEND: begin
               if (out_rdy) begin
                  if (cnt_q == 4'd8) begin
                     state_q      <= ST_IDLE;
                     req_ready_q  <= 1'b1;
                     cnt_q        <= 4'd0;
                     out_data_q   <= 64'h0;
                     out_ctrl_q   <= 8'h00;
                     ip_id_q      <= ip_id_q + 16'd1;
                     tx_pkt_cnt_q <= tx_pkt_cnt_q + 32'd1;
                  end else begin
                     cnt_q      <= cnt_q + 4'd1;
                     out_data_q <= body_word(cnt_q + 4'd1, dst_mac_q, src_mac_q, src_ip_q,
                                             dst_ip_q, ip_id_q, proto_q, cksum_s);
                     out_ctrl_q <= (cnt_q == 4'd7) ? 8'h10 : 8'h00;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign out_wr     = (state_q == ST_SEND) && out_rdy;
   assign out_data   = out_data_q;
   assign out_ctrl   = out_ctrl_q;
   assign tx_pkt_cnt = tx_pkt_cnt_q;

endmodule

// File: tb/tb_as_ethernet_pkt_gen.sv
// Directed bench for as_ethernet_pkt_gen: reset, basic, backpressure, back-to-back, id wrap, mid-packet reset.
module tb_as_ethernet_pkt_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [47:0] req_dst_mac = 48'h0;
   logic [47:0] req_src_mac = 48'h0;
   logic [31:0] req_src_ip = 32'h0;
   logic [31:0] req_dst_ip = 32'h0;
   logic [7:0]  req_proto = 8'h0;
   logic [2:0]  req_dst_port = 3'd0;
   logic [2:0]  req_src_port = 3'd0;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy = 1'b1;
   logic [31:0] tx_pkt_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wcount = 0;
   int acc_n = 0;
   int acc_edge [0:3];
   logic [63:0] cap_d [0:31];
   logic [7:0]  cap_c [0:31];
   int          cap_edge [0:31];
   logic        bp_en = 1'b0;

`ifdef AS_PKT_GEN_CKSUM_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic [47:0] B_DMAC = 48'h001122334455;
   localparam logic [47:0] B_SMAC = 48'h66778899AABB;
   localparam logic [31:0] B_SIP  = 32'hC0A80001;
   localparam logic [31:0] B_DIP  = 32'hC0A80002;

   as_ethernet_pkt_gen dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac), .req_src_ip(req_src_ip),
      .req_dst_ip(req_dst_ip), .req_proto(req_proto), .req_dst_port(req_dst_port),
      .req_src_port(req_src_port), .out_data(out_data), .out_ctrl(out_ctrl),
      .out_wr(out_wr), .out_rdy(out_rdy), .tx_pkt_cnt(tx_pkt_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bp_en) begin #1; out_rdy = ~out_rdy; end

   // Inputs only change just after posedge, so what is seen at negedge is what the next edge writes.
   always @(negedge clk) begin
      if (out_wr) begin
         checks++;
         assert (out_rdy === 1'b1) else begin
            failures++;
            $error("FAIL wr_without_rdy observed=%b expected=1", out_rdy);
         end
         if (wcount < 32) begin
            cap_d[wcount]    = out_data;
            cap_c[wcount]    = out_ctrl;
            cap_edge[wcount] = cyc + 1;
         end
         wcount++;
      end
   end

   function automatic logic [15:0] ck(input logic [15:0] v);
`ifdef AS_PKT_GEN_CKSUM_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic logic [63:0] exp_word(input int i, input logic [47:0] dm, input logic [47:0] sm,
                                            input logic [31:0] si, input logic [31:0] di,
                                            input logic [7:0] pr, input logic [2:0] dp,
                                            input logic [2:0] sp, input logic [15:0] id,
                                            input logic [15:0] cs);
      logic [15:0] oh;
      oh = 16'd1 << dp;
      case (i)
         0:       return {oh, 16'd8, 13'd0, sp, 16'd60};
         1:       return {dm, sm[47:32]};
         2:       return {sm[31:0], 16'h0800, 8'h45, 8'h00};
         3:       return {16'd46, id, 16'h4000, 8'd64, pr};
         4:       return {cs, si, di[31:16]};
         5:       return {di[15:0], 48'h0};
         default: return 64'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [47:0] dm, input logic [47:0] sm, input logic [31:0] si,
                       input logic [31:0] di, input logic [7:0] pr, input logic [2:0] dp,
                       input logic [2:0] sp, input int n_acc);
      int got;
      got = 0;
      req_dst_mac = dm; req_src_mac = sm; req_src_ip = si; req_dst_ip = di;
      req_proto = pr; req_dst_port = dp; req_src_port = sp; req_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (req_ready) begin
            acc_edge[acc_n] = cyc + 1;
            acc_n++;
            got++;
            if (got == n_acc) begin
               @(posedge clk); #1;
               req_valid = 1'b0;
               req_dst_mac = {$urandom, $urandom}; req_src_mac = {$urandom, $urandom};
               req_src_ip = $urandom; req_dst_ip = $urandom; req_proto = 8'($urandom);
               req_dst_port = 3'($urandom); req_src_port = 3'($urandom);
               return;
            end
         end
      end
      req_valid = 1'b0;
      chk("accept_timeout", 64'(got), 64'(n_acc));
   endtask

   task automatic wait_words(input int n);
      for (int k = 0; k < 400; k++) begin
         if (wcount >= n) return;
         @(posedge clk); #1;
      end
      chk("word_timeout", 64'(wcount), 64'(n));
   endtask

   task automatic check_pkt(input string tag, input int base, input logic [47:0] dm,
                            input logic [47:0] sm, input logic [31:0] si, input logic [31:0] di,
                            input logic [7:0] pr, input logic [2:0] dp, input logic [2:0] sp,
                            input logic [15:0] id, input logic [15:0] cs);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s_w%0d", tag, i), cap_d[base+i], exp_word(i, dm, sm, si, di, pr, dp, sp, id, cs));
         chk($sformatf("%s_c%0d", tag, i), 64'(cap_c[base+i]),
             (i == 0) ? 64'hFF : ((i == 8) ? 64'h10 : 64'h00));
      end
   endtask

   task automatic start_pkt();
      wcount = 0;
      acc_n  = 0;
   endtask

   initial begin
      // Reset asserted mid-cycle before the first edge
      #3 reset_n = 1'b0;
      #1;
      chk("rst_out_wr", 64'(out_wr), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      // Basic packet, id 0
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(9);
      chk("basic_w0_const", cap_d[0], 64'h0004_0008_0000_003C);
      chk("basic_cksum", 64'(cap_d[4][63:48]), 64'(ck(16'hB97B)));
      check_pkt("basic", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0000, ck(16'hB97B));
      chk("basic_latency", 64'(cap_edge[0] - acc_edge[0]), 64'(LAT));
      chk("basic_tx_cnt", 64'(tx_pkt_cnt), 64'd1);

      // Backpressure: out_rdy toggles every cycle, id 1
      start_pkt();
      bp_en = 1'b1;
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(9);
      bp_en = 1'b0;
      @(posedge clk); #2 out_rdy = 1'b1;
      check_pkt("bp", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0001, ck(16'hB97A));
      chk("bp_tx_cnt", 64'(tx_pkt_cnt), 64'd2);

      // Back-to-back with req_valid held, ids 2 and 3
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 2);
      wait_words(18);
      check_pkt("b2b_a", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0002, ck(16'hB979));
      check_pkt("b2b_b", 9, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0003, ck(16'hB978));
      chk("b2b_accept_after_w8", 64'(acc_edge[1] - cap_edge[8]), 64'd1);
      chk("b2b_latency", 64'(cap_edge[9] - acc_edge[1]), 64'(LAT));
      chk("b2b_tx_cnt", 64'(tx_pkt_cnt), 64'd4);

      // Distinct fields and ports, id 4; inputs are scrambled right after accept
      start_pkt();
      send(48'hFEDCBA987654, 48'h0A0B0C0D0E0F, 32'h0A000001, 32'h0A0000FE, 8'h11, 3'd7, 3'd5, 1);
      wait_words(9);
      chk("dist_w0_const", cap_d[0], 64'h0080_0008_0005_003C);
      check_pkt("dist", 0, 48'hFEDCBA987654, 48'h0A0B0C0D0E0F, 32'h0A000001, 32'h0A0000FE,
                8'h11, 3'd7, 3'd5, 16'h0004, ck(16'h25BD));
      chk("dist_tx_cnt", 64'(tx_pkt_cnt), 64'd5);

      // Reset in the middle of SEND after four words
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(4);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_out_wr", 64'(out_wr), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      chk("midrst_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(9);
      check_pkt("post_rst", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0000, ck(16'hB97B));
      chk("post_rst_tx_cnt", 64'(tx_pkt_cnt), 64'd1);

      // ip_id wrap: FFFF then 0000
      @(posedge clk); #1;
      force dut.ip_id_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.ip_id_q;
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(9);
      check_pkt("wrap_ffff", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'hFFFF, ck(16'hB97B));
      start_pkt();
      send(B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 1);
      wait_words(9);
      check_pkt("wrap_0000", 0, B_DMAC, B_SMAC, B_SIP, B_DIP, 8'h01, 3'd2, 3'd0, 16'h0000, ck(16'hB97B));
      chk("wrap_tx_cnt", 64'(tx_pkt_cnt), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
